// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: valid/ready word load, MSB- or LSB-first shift-out on sout.
// Define PISO_PARITY_EN to append an even-parity bit after the N data bits.
module piso_serializer #(
    parameter int   N          = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] din,
    input  logic         dir,
    output logic         sout,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] count_q, count_d;
    logic          dir_q, dir_d;
    logic          sout_q, sout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef PISO_PARITY_EN
    logic          parity_q, parity_d;
`endif

    // Handshake: a word is taken on a posedge where load_valid && load_ready.
    assign load_ready = (state_q == IDLE) && en && rst;
    assign sout       = sout_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        dir_d   = dir_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        // The first bit leaves on the load edge; the register keeps the remainder.
                        dir_d   = dir;
                        sout_d  = dir ? din[0] : din[N-1];
                        shreg_d = dir ? (din >> 1) : (din << 1);
                        count_d = CW'(1);
                        state_d = SHIFT;
                        busy_d  = 1'b1;
`ifdef PISO_PARITY_EN
                        parity_d = ^din;
`endif
                    end
                end
                SHIFT: begin
                    if (count_q < LAST_CNT) begin
                        sout_d  = dir_q ? shreg_q[0] : shreg_q[N-1];
                        shreg_d = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
                        count_d = count_q + CW'(1);
                    end else begin
`ifdef PISO_PARITY_EN
                        sout_d  = parity_q;
                        state_d = PARITY;
`else
                        sout_d  = IDLE_LEVEL;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end
                end
                PARITY: begin
                    sout_d  = IDLE_LEVEL;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    sout_d  = IDLE_LEVEL;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
            sout_q  <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed frames from the test plan plus randomized frames
// compared against a bit-list reference model.
module tb_piso_serializer;

    localparam int   N          = 4;
    localparam logic IDLE_LEVEL = 1'b0;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [N-1:0] din = '0;
    logic         dir = 1'b0;
    logic         sout;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [0:0] exp_q[$];

    piso_serializer #(.N(N), .IDLE_LEVEL(IDLE_LEVEL)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .din        (din),
        .dir        (dir),
        .sout       (sout),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; return at the negedge with registered outputs settled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: the bits a frame must put on sout, in order.
    task automatic build_expected(input logic [N-1:0] word, input logic d);
        exp_q.delete();
        for (int i = 0; i < N; i++)
            exp_q.push_back(d ? word[i] : word[N-1-i]);
`ifdef PISO_PARITY_EN
        exp_q.push_back(^word);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b0;
        load_valid = 1'b1;
        en = 1'(($urandom_range(0, 1)));
        step();
        step();
        check("rst_sout", sout, IDLE_LEVEL);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", load_ready, 0);
        load_valid = 1'b0;
        rst = 1'b1;
        en = 1'b1;
        #1;
        check("rst_release_ready", load_ready, 1);
    endtask

    // Send one frame. stalls: insert random en=0 gaps. abort_at: reset after that many bits (0 = none).
    task automatic send_frame(input logic [N-1:0] word, input logic d, input bit stalls, input int abort_at);
        logic [0:0] cur;
        int sent;
        build_expected(word, d);
        din = word;
        dir = d;
        en = 1'b1;
        load_valid = 1'b1;
        #1;
        check("load_ready_idle", load_ready, 1);
        step();
        // Scramble inputs after the load edge; the frame must not notice.
        load_valid = 1'(($urandom_range(0, 1)));
        din = N'($urandom);
        dir = 1'(($urandom_range(0, 1)));
        cur = exp_q.pop_front();
        check("first_bit", sout, cur);
        check("first_busy", busy, 1);
        check("first_done", done, 0);
        sent = 1;
        while (exp_q.size() > 0) begin
            if (abort_at != 0 && sent == abort_at) begin
                rst = 1'b0;
                step();
                rst = 1'b1;
                load_valid = 1'b0;
                check("abort_sout", sout, IDLE_LEVEL);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                step();
                check("abort_no_done", done, 0);
                return;
            end
            if (stalls) begin
                int gaps = $urandom_range(0, 3);
                for (int g = 0; g < gaps; g++) begin
                    en = 1'b0;
                    step();
                    check("stall_sout", sout, cur);
                    check("stall_busy", busy, 1);
                    check("stall_done", done, 0);
                end
            end
            en = 1'b1;
            #1;
            check("busy_ready", load_ready, 0);
            step();
            load_valid = 1'(($urandom_range(0, 1)));
            cur = exp_q.pop_front();
            check("bit", sout, cur);
            check("bit_busy", busy, 1);
            check("bit_done", done, 0);
            sent++;
        end
        en = 1'b1;
        step();
        load_valid = 1'b0;
        check("end_sout", sout, IDLE_LEVEL);
        check("end_busy", busy, 0);
        check("end_done", done, 1);
        en = 1'(($urandom_range(0, 1)));
        step();
        check("gap_done_clear", done, 0);
        check("gap_busy", busy, 0);
        check("gap_sout", sout, IDLE_LEVEL);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        send_frame(4'b1011, 1'b0, 1'b0, 0);
        send_frame(4'b1011, 1'b1, 1'b0, 0);
        send_frame(4'b1011, 1'b0, 1'b1, 0);
        send_frame(4'b1001, 1'b0, 1'b0, 0);

        // No load while en is low in IDLE.
        en = 1'b0;
        load_valid = 1'b1;
        din = 4'b1111;
        #1;
        check("en0_ready", load_ready, 0);
        step();
        check("en0_busy", busy, 0);
        check("en0_sout", sout, IDLE_LEVEL);
        load_valid = 1'b0;
        en = 1'b1;

        send_frame(4'b1101, 1'b0, 1'b0, 2);
        send_frame(4'b0110, 1'b0, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            int ab;
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, N - 1)) : 0;
            send_frame(N'($urandom), 1'(($urandom_range(0, 1))), 1'b1, ab);
        end

        do_reset();
        send_frame(4'b0101, 1'b1, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
